// File: rtl/alu_reg_if.sv
// Operand/control and registered-result bundle for the execute-stage ALU.
// The master side drives operands and control; the slave side (the ALU) returns results.
interface alu_reg_if #(
  parameter int N = 8
);
  logic         i_valid;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic [1:0]   i_alu_ctrl;
  logic [N-1:0] o_result;
  logic         o_carry_out;
  logic         o_zero;
  logic         o_negative;
  logic         o_overflow;
  logic         o_valid;

  modport master (
    output i_valid, i_a, i_b, i_alu_ctrl,
    input  o_result, o_carry_out, o_zero, o_negative, o_overflow, o_valid
  );

  modport slave (
    input  i_valid, i_a, i_b, i_alu_ctrl,
    output o_result, o_carry_out, o_zero, o_negative, o_overflow, o_valid
  );
endinterface

// File: rtl/alu_reg.sv
// Registered N-bit ALU: add, subtract, AND, OR with carry and status flags.
// One shared adder serves both add and subtract; its carry is reported for every
// operation code, including the logic ops. All outputs have one cycle of latency.
module alu_reg #(
  parameter int N = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_reg_if.slave bus
);

  logic [N-1:0] b_op;
  logic [N:0]   add_full;
  logic [N-1:0] sum;
  logic         carry;
  logic [N-1:0] result;
  logic         overflow;

  // Shared adder: ctrl[0] selects A + ~B + 1 (subtract) instead of A + B.
  always_comb begin
    b_op     = bus.i_alu_ctrl[0] ? ~bus.i_b : bus.i_b;
    add_full = {1'b0, bus.i_a} + {1'b0, b_op} + {{N{1'b0}}, bus.i_alu_ctrl[0]};
    sum      = add_full[N-1:0];
    carry    = add_full[N];
  end

  // Result select and signed-overflow detection; logic ops never overflow.
  always_comb begin
    result   = sum;
    overflow = 1'b0;
    case (bus.i_alu_ctrl)
      2'b00: begin
        result   = sum;
        overflow = (bus.i_a[N-1] == bus.i_b[N-1]) && (sum[N-1] != bus.i_a[N-1]);
      end
      2'b01: begin
        result   = sum;
        overflow = (bus.i_a[N-1] != bus.i_b[N-1]) && (sum[N-1] != bus.i_a[N-1]);
      end
      2'b10: result = bus.i_a & bus.i_b;
      2'b11: result = bus.i_a | bus.i_b;
      default: begin
        result   = sum;
        overflow = 1'b0;
      end
    endcase
  end

  // Output registers; reset wins over inputs sampled at the same edge, and o_zero
  // clears to 0 under reset even though the cleared result is 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_result    <= '0;
      bus.o_carry_out <= 1'b0;
      bus.o_zero      <= 1'b0;
      bus.o_negative  <= 1'b0;
      bus.o_overflow  <= 1'b0;
      bus.o_valid     <= 1'b0;
    end else begin
      bus.o_result    <= result;
      bus.o_carry_out <= carry;
      bus.o_zero      <= (result == '0);
      bus.o_negative  <= result[N-1];
      bus.o_overflow  <= overflow;
      bus.o_valid     <= bus.i_valid;
    end
  end

endmodule

// File: tb/tb_alu_reg.sv
// Self-checking bench for alu_reg: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_reg;
  localparam int N = 8;
  localparam int MOD = 1 << N;
  localparam int HALF = 1 << (N - 1);

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_reg_if #(.N(N)) bus ();

  alu_reg #(.N(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected registered outputs from the reference model
  logic         known;
  logic [N-1:0] e_result;
  logic         e_carry, e_zero, e_neg, e_ovf, e_valid;

  function automatic int to_signed(input int u);
    return (u >= HALF) ? u - MOD : u;
  endfunction

  // Reference model: plain integer arithmetic on unsigned/signed interpretations.
  always @(posedge clk) begin
    int ua, ub, sa, sb, r, sr;
    ua = int'(bus.i_a);
    ub = int'(bus.i_b);
    sa = to_signed(ua);
    sb = to_signed(ub);
    if (rst) begin
      known    <= 1'b1;
      e_result <= '0;
      e_carry  <= 1'b0;
      e_zero   <= 1'b0;
      e_neg    <= 1'b0;
      e_ovf    <= 1'b0;
      e_valid  <= 1'b0;
    end else begin
      r = 0;
      e_ovf <= 1'b0;
      case (bus.i_alu_ctrl)
        2'd0: begin
          r  = (ua + ub) % MOD;
          sr = sa + sb;
          e_ovf <= (sr >= HALF) || (sr < -HALF);
        end
        2'd1: begin
          r  = (ua - ub + MOD) % MOD;
          sr = sa - sb;
          e_ovf <= (sr >= HALF) || (sr < -HALF);
        end
        2'd2: r = int'(bus.i_a & bus.i_b);
        default: r = int'(bus.i_a | bus.i_b);
      endcase
      e_carry  <= bus.i_alu_ctrl[0] ? (ua >= ub) : ((ua + ub) >= MOD);
      e_result <= N'(r);
      e_zero   <= (r == 0);
      e_neg    <= (r >= HALF);
      e_valid  <= bus.i_valid;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model once reset has been seen.
  always @(posedge clk) begin
    #1;
    if (known) begin
      check("model.result",   int'(bus.o_result),    int'(e_result));
      check("model.carry",    int'(bus.o_carry_out), int'(e_carry));
      check("model.zero",     int'(bus.o_zero),      int'(e_zero));
      check("model.negative", int'(bus.o_negative),  int'(e_neg));
      check("model.overflow", int'(bus.o_overflow),  int'(e_ovf));
      check("model.valid",    int'(bus.o_valid),     int'(e_valid));
    end
  end

  task automatic apply(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [1:0] ctrl, input logic v);
    @(negedge clk);
    bus.i_a        = a;
    bus.i_b        = b;
    bus.i_alu_ctrl = ctrl;
    bus.i_valid    = v;
  endtask

  // Wait for the edge that captures the last applied inputs, then pin literal values.
  task automatic expect_lit(input string name, input int res, input int c, input int z,
                            input int neg, input int ovf, input int v);
    @(posedge clk);
    #2;
    check({name, ".result"},   int'(bus.o_result),    res);
    check({name, ".carry"},    int'(bus.o_carry_out), c);
    check({name, ".zero"},     int'(bus.o_zero),      z);
    check({name, ".negative"}, int'(bus.o_negative),  neg);
    check({name, ".overflow"}, int'(bus.o_overflow),  ovf);
    check({name, ".valid"},    int'(bus.o_valid),     v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    known = 1'b0;
    rst = 1'b1;
    bus.i_a = 8'h7F; bus.i_b = 8'h81; bus.i_alu_ctrl = 2'b00; bus.i_valid = 1'b1;

    // reset for two cycles with arbitrary inputs
    @(posedge clk);
    apply(8'hBD, 8'hA5, 2'b01, 1'b1);
    expect_lit("reset", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    bus.i_a = 8'h00; bus.i_b = 8'h00; bus.i_alu_ctrl = 2'b00; bus.i_valid = 1'b1;
    expect_lit("zero_add", 8'h00, 0, 1, 0, 0, 1);

    apply(8'h05, 8'h06, 2'b01, 1'b1);
    expect_lit("sub_borrow", 8'hFF, 0, 0, 1, 0, 1);

    // four ops back to back, each exactly one edge after its inputs
    apply(8'hBD, 8'hA5, 2'b00, 1'b1);
    expect_lit("add_carry", 8'h62, 1, 0, 0, 1, 1);
    apply(8'hBD, 8'hA5, 2'b01, 1'b1);
    expect_lit("sub", 8'h18, 1, 0, 0, 0, 1);
    apply(8'hBD, 8'hA5, 2'b10, 1'b1);
    expect_lit("and", 8'hA5, 1, 0, 1, 0, 1);
    apply(8'hBD, 8'hA5, 2'b11, 1'b1);
    expect_lit("or", 8'hBD, 1, 0, 1, 0, 1);

    // reset mid-stream discards the in-flight op
    apply(8'h7F, 8'h01, 2'b00, 1'b1);
    expect_lit("add_ovf", 8'h80, 0, 0, 1, 1, 1);
    apply(8'h40, 8'h40, 2'b00, 1'b1);
    rst = 1'b1;
    expect_lit("mid_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_a = 8'h80; bus.i_b = 8'h01; bus.i_alu_ctrl = 2'b01; bus.i_valid = 1'b0;
    expect_lit("sub_ovf_novalid", 8'h7F, 1, 0, 0, 1, 0);

    // boundary operands across all codes, valid toggled; checked by the model
    begin
      logic [N-1:0] edge_v [6];
      edge_v = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++)
          for (int k = 0; k < 4; k++)
            apply(edge_v[i], edge_v[j], 2'(k), 1'((i + j + k) & 1));
    end

    for (int n = 0; n < 200; n++)
      apply(N'($urandom), N'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
